// File: rtl/disp_slice_scheduler.sv
// Purpose: sequence a double-buffered stack of 16x16 slices onto the 256-bit scan-driver matrix input.
// Latency: mat_out/slice_idx are registered and update on the advance edge itself; bank swap lands on a frame boundary.
// Backpressure: wr_ready drops while a commit is pending and returns at the swap. Optional blanking: DISP_SLICE_BLANK_EN.
module disp_slice_scheduler #(
  parameter int NUM_SLICES   = 8,
  parameter int SLICE_W      = 3,
  parameter int DWELL        = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               sync,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [SLICE_W-1:0] wr_slice,
  input  logic [3:0]         wr_row,
  input  logic [0:15]        wr_data,
  input  logic               commit,
  output logic               commit_done,
  output logic [0:255]       mat_out,
  output logic [SLICE_W-1:0] slice_idx,
  output logic               frame_start
);

  localparam int IDX_W      = $clog2(NUM_SLICES);
  localparam int CNT_W      = $clog2(DWELL);
  localparam int BLANK_FROM = DWELL - BLANK_CYCLES;
`ifdef DISP_SLICE_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               front_sel;
  logic               swap_pending;
  logic [0:255]       mat_q;
  logic [0:15]        bank [2][NUM_SLICES][16];

  logic               last_tick;
  logic               last_slice;
  logic               entry;
  logic               boundary;
  logic               swap_go;
  logic               front_nxt;
  logic [SLICE_W-1:0] slice_nxt;
  logic               wr_ok;
  logic [0:255]       rd_frame;

  assign last_tick  = (cnt == CNT_W'(DWELL - 1));
  assign last_slice = (slice_idx == SLICE_W'(NUM_SLICES - 1));
  assign entry      = (state == IDLE) && enable;
  // A frame boundary is the IDLE exit, a sync restart, or the natural wrap back to slice 0.
  assign boundary   = entry || ((state == RUN) && enable && (sync || (last_tick && last_slice)));
  // While idle a pending swap needs no boundary: nothing is on screen to tear.
  assign swap_go    = swap_pending && ((state == IDLE) || boundary);
  assign front_nxt  = front_sel ^ swap_go;
  assign slice_nxt  = ((state == IDLE) || sync || last_slice) ? '0 : slice_idx + SLICE_W'(1);
  assign wr_ok      = wr_valid && wr_ready && ({1'b0, wr_slice} < (SLICE_W + 1)'(NUM_SLICES));

  // Gather the slice about to be shown, from the bank that will be front after this edge.
  always_comb begin
    rd_frame = '0;
    for (int r = 0; r < 16; r++) begin
      rd_frame[r*16 +: 16] = bank[front_nxt][slice_nxt[IDX_W-1:0]][r[3:0]];
    end
  end

  // Scheduler FSM: dwell counting, slice advance, commit handshake and bank swap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      slice_idx    <= '0;
      mat_q        <= '0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      wr_ready     <= 1'b1;
      commit_done  <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      commit_done <= swap_go;
      frame_start <= boundary;
      if (swap_go) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
        wr_ready     <= 1'b1;
      end else if (commit) begin
        swap_pending <= 1'b1;
        wr_ready     <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= RUN;
            cnt       <= '0;
            slice_idx <= '0;
            mat_q     <= rd_frame;
          end
        end
        RUN: begin
          if (!enable) begin
            state     <= IDLE;
            cnt       <= '0;
            slice_idx <= '0;
            mat_q     <= '0;
          end else if (sync || last_tick) begin
            cnt       <= '0;
            slice_idx <= slice_nxt;
            mat_q     <= rd_frame;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Loader writes go only to the back bank; out-of-range slice writes are swallowed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < NUM_SLICES; s++) begin
          for (int r = 0; r < 16; r++) begin
            bank[b[0]][s[IDX_W-1:0]][r[3:0]] <= '0;
          end
        end
      end
    end else if (wr_ok) begin
      bank[~front_sel][wr_slice[IDX_W-1:0]][wr_row] <= wr_data;
    end
  end

  // Anti-ghosting gap: dark tail of each slice when blanking is built in.
  assign mat_out = (BLANK_ON && (state == RUN) && (cnt >= CNT_W'(BLANK_FROM))) ? '0 : mat_q;

endmodule

// File: doc/disp_slice_scheduler.md
Name: disp_slice_scheduler

Overview:
- Sequences a stack of 16x16 bitmaps ("slices" of a 3D image) into the 256-bit matrix input of the row/column scan display driver.
- Each slice is shown for a fixed dwell time. The slice counter can be restarted by an external index pulse, e.g. a rotation sensor.
- Double-buffered slice store: a loader writes the back bank row by row, then commits. The bank swap happens only at a frame boundary, so the viewer never sees a torn frame.

Parameters:
- NUM_SLICES, 8: slices per frame, 2..16.
- SLICE_W, 3: width of slice index; must be at least clog2(NUM_SLICES).
- DWELL, 1024: clock cycles per slice, at least 4.
- BLANK_CYCLES, 16: blanking length, less than DWELL; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run the scheduler; low forces IDLE.
- sync  in  1  single-cycle pulse: restart at slice 0.
- wr_valid  in  1  loader row write request.
- wr_ready  out  1  row write accepted when wr_valid and wr_ready are both high.
- wr_slice  in  SLICE_W  target slice in the back bank.
- wr_row  in  4  target row 0..15.
- wr_data  in  [0:15]  row bitmap; bit 0 is column 0; 1 means LED on.
- commit  in  1  pulse: request back/front bank swap.
- commit_done  out  1  one-cycle pulse in the cycle the swap takes effect.
- mat_out  out  [0:255]  displayed slice; row r occupies bits r*16..r*16+15.
- slice_idx  out  SLICE_W  index of the slice currently on mat_out.
- frame_start  out  1  one-cycle pulse when slice 0 is loaded onto mat_out.

Behaviour:
- Reset values:
  - state IDLE; front bank is bank 0; both banks cleared to 0.
  - mat_out 0, slice_idx 0, wr_ready 1, commit_done 0, frame_start 0.
  - dwell counter 0, swap_pending 0.
- States: IDLE and RUN.
  - IDLE: mat_out is 0 and slice_idx is 0.
  - IDLE to RUN on the first edge where enable=1. After that edge: slice_idx=0, mat_out=front[0], frame_start=1, dwell counter=0.
  - RUN to IDLE on any edge where enable=0. After that edge: mat_out=0, slice_idx=0, pending commit kept.
- RUN slice advance:
  - The dwell counter increments every cycle.
  - When it equals DWELL-1, the next edge clears it and advances the slice.
  - slice_idx becomes slice_idx+1, or wraps to 0 after NUM_SLICES-1.
  - mat_out loads front[new slice] on that same edge (registered, zero extra latency relative to slice_idx).
  - frame_start=1 for one cycle when the new slice is 0.
- sync:
  - sync=1 in RUN restarts at slice 0 on the next edge: counter=0, frame_start=1, regardless of the current count.
  - sync coinciding with a natural wrap produces one restart only.
  - sync is ignored in IDLE.
- Frame boundary: any edge producing frame_start=1, or the IDLE-to-RUN entry.
- Writes:
  - An accepted write stores wr_data into back[wr_slice][wr_row].
  - A write with wr_slice >= NUM_SLICES is accepted and discarded.
  - The front bank is never written, so mat_out is stable within a slice.
- Commit:
  - commit=1 sets swap_pending; wr_ready drops to 0 on the next edge.
  - A wr_valid in the same cycle as commit is still accepted and lands before the swap.
  - In IDLE the swap occurs on the next edge.
  - In RUN the swap occurs at the next frame boundary. The newly loaded slice 0 is then read from the new front bank.
  - At the swap: commit_done=1 for one cycle, swap_pending=0, wr_ready=1 again.
  - Further commits while pending are ignored.
  - The old front bank becomes the back bank with contents unchanged; no auto-clear.
- Asynchronous reset mid-operation returns everything to the reset values immediately. Any pending commit is lost.

Optional Feature:
- Macro: DISP_SLICE_BLANK_EN.
- Defined: in RUN, mat_out is forced to all zeros while the dwell counter is at least DWELL-BLANK_CYCLES. This is an anti-ghosting gap before each slice change. slice_idx is unaffected, and mat_out shows the next slice on the advance edge as normal.
- Undefined: no blanking; BLANK_CYCLES is ignored.

Test Plan:
All scenarios use NUM_SLICES=4, DWELL=8, BLANK_CYCLES=2 unless noted.
- Reset then enable=1:
  - Next cycle: frame_start=1, slice_idx=0, mat_out all zeros.
  - slice_idx steps 1,2,3,0 every 8 cycles; frame_start pulses every 32 cycles.
- Write back[2][5]=16'hA5A5, then commit in RUN:
  - wr_ready=0 until the next frame boundary; commit_done coincides with frame_start.
  - When slice_idx=2, mat_out bits 80..95 equal A5A5 and all other bits are 0.
- sync pulse while slice_idx=1, counter=3:
  - Next cycle: slice_idx=0, frame_start=1.
  - The following advance occurs 8 cycles later.
- sync and natural wrap in the same cycle:
  - Exactly one frame_start pulse; the next advance 8 cycles later.
- enable dropped mid-slice with a commit pending:
  - mat_out=0 next cycle.
  - Swap, with commit_done, on the following edge while IDLE; wr_ready returns to 1.
- With DISP_SLICE_BLANK_EN defined and all slices all-ones:
  - mat_out is all-ones for counter 0..5 and zero for counter 6..7 of each slice.
  - Without the macro, mat_out stays all-ones throughout.
